// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong engine.
package pong_pkg;

  localparam int POS_W   = 10;
  localparam int ARITH_W = 11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    GAMEOVER = 3'd3
  } state_t;

  // x: DIR_POS = rightward; y: DIR_POS = downward
  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  typedef logic signed [ARITH_W-1:0] sarith_t;

  // Zero-extend a position into the signed arithmetic domain.
  function automatic sarith_t to_s(input logic [POS_W-1:0] v);
    return sarith_t'({1'b0, v});
  endfunction

endpackage

// File: rtl/pong_if.sv
// Button inputs and renderer-facing game state of the Pong engine.
interface pong_if #(
  parameter int SCORE_W = 4
);
  import pong_pkg::*;

  logic               tick;
  logic               start;
  logic               p1_up;
  logic               p1_dn;
  logic               p2_up;
  logic               p2_dn;
  logic [2:0]         state_out;
  logic [POS_W-1:0]   p1_y;
  logic [POS_W-1:0]   p2_y;
  logic [POS_W-1:0]   ball_x;
  logic [POS_W-1:0]   ball_y;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               point1;
  logic               point2;
  logic [1:0]         winner;

  modport master (
    output tick, start, p1_up, p1_dn, p2_up, p2_dn,
    input  state_out, p1_y, p2_y, ball_x, ball_y,
           score1, score2, point1, point2, winner
  );

  modport slave (
    input  tick, start, p1_up, p1_dn, p2_up, p2_dn,
    output state_out, p1_y, p2_y, ball_x, ball_y,
           score1, score2, point1, point2, winner
  );

endinterface

// File: rtl/pong_paddle.sv
// Saturating paddle position register; moves one step per enabled cycle.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int PAD_H     = 64,
  parameter int FIELD_H   = 480,
  parameter int PAD_SPEED = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_dn,
  output logic [POS_W-1:0] o_y
);

  localparam sarith_t          L_SPEED = sarith_t'(PAD_SPEED);
  localparam sarith_t          L_MAX   = sarith_t'(FIELD_H - PAD_H);
  localparam sarith_t          L_ZERO  = '0;
  localparam logic [POS_W-1:0] L_RST   = POS_W'((FIELD_H - PAD_H) / 2);

  logic [POS_W-1:0] r_y;
  logic [POS_W-1:0] w_y_next;
  sarith_t          w_up;
  sarith_t          w_dn;

  // Next position with saturation at the top and bottom of the field
  always_comb begin
    w_up     = to_s(r_y) - L_SPEED;
    w_dn     = to_s(r_y) + L_SPEED;
    w_y_next = r_y;
    if (i_up && !i_dn)
      w_y_next = (w_up < L_ZERO) ? '0 : w_up[POS_W-1:0];
    else if (i_dn && !i_up)
      w_y_next = (w_dn > L_MAX) ? L_MAX[POS_W-1:0] : w_dn[POS_W-1:0];
  end

  // Position register
  always_ff @(posedge clk) begin
    if (rst)       r_y <= L_RST;
    else if (i_en) r_y <= w_y_next;
  end

  assign o_y = r_y;

endmodule

// File: rtl/pong_core.sv
// Pong game engine: paddles, ball, scoring, timed serve and win detection.
module pong_core
  import pong_pkg::*;
#(
  parameter int FIELD_W     = 640,
  parameter int FIELD_H     = 480,
  parameter int PAD_H       = 64,
  parameter int PAD_X_L     = 24,
  parameter int PAD_X_R     = 616,
  parameter int BALL_SZ     = 8,
  parameter int PAD_SPEED   = 4,
  parameter int BALL_SPEED  = 2,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 4
) (
  input logic   clk,
  input logic   rst,
  pong_if.slave bus
);

  localparam int CNT_W = $clog2(SERVE_TICKS + 1);

  localparam sarith_t L_BS     = sarith_t'(BALL_SPEED);
  localparam sarith_t L_SZ     = sarith_t'(BALL_SZ);
  localparam sarith_t L_PH     = sarith_t'(PAD_H);
  localparam sarith_t L_XL     = sarith_t'(PAD_X_L);
  localparam sarith_t L_XR     = sarith_t'(PAD_X_R);
  localparam sarith_t L_YMAX   = sarith_t'(FIELD_H - BALL_SZ);
  localparam sarith_t L_XL_HIT = sarith_t'(PAD_X_L + 1);
  localparam sarith_t L_XR_HIT = sarith_t'(PAD_X_R - BALL_SZ - 1);
  localparam sarith_t L_ZERO   = '0;

  localparam logic [POS_W-1:0]   L_BX_C  = POS_W'((FIELD_W - BALL_SZ) / 2);
  localparam logic [POS_W-1:0]   L_BY_C  = POS_W'((FIELD_H - BALL_SZ) / 2);
  localparam logic [CNT_W-1:0]   L_LAST  = CNT_W'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0] L_WIN   = SCORE_W'(WIN_SCORE);

  state_t             r_state;
  logic [POS_W-1:0]   r_bx;
  logic [POS_W-1:0]   r_by;
  dir_t               r_xdir;
  dir_t               r_ydir;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic               r_point1;
  logic               r_point2;
  winner_t            r_winner;

  logic               w_pad_en;
  logic [POS_W-1:0]   w_p1_y;
  logic [POS_W-1:0]   w_p2_y;
  sarith_t            w_bx;
  sarith_t            w_by;
  sarith_t            w_nx;
  sarith_t            w_ny;
  dir_t               w_nxdir;
  dir_t               w_nydir;
  logic               w_pt1;
  logic               w_pt2;
  logic [SCORE_W-1:0] w_s1_inc;
  logic [SCORE_W-1:0] w_s2_inc;

  assign w_pad_en = bus.tick && (r_state == SERVE || r_state == PLAY);

  pong_paddle #(.PAD_H(PAD_H), .FIELD_H(FIELD_H), .PAD_SPEED(PAD_SPEED)) u_pad1 (
    .clk(clk), .rst(rst), .i_en(w_pad_en),
    .i_up(bus.p1_up), .i_dn(bus.p1_dn), .o_y(w_p1_y)
  );

  pong_paddle #(.PAD_H(PAD_H), .FIELD_H(FIELD_H), .PAD_SPEED(PAD_SPEED)) u_pad2 (
    .clk(clk), .rst(rst), .i_en(w_pad_en),
    .i_up(bus.p2_up), .i_dn(bus.p2_dn), .o_y(w_p2_y)
  );

  assign w_s1_inc = r_score1 + SCORE_W'(1);
  assign w_s2_inc = r_score2 + SCORE_W'(1);

  // Ball step for one play tick; paddle hit tests use the pre-tick paddle registers
  always_comb begin
    w_bx    = to_s(r_bx);
    w_by    = to_s(r_by);
    w_nx    = w_bx;
    w_ny    = w_by;
    w_nxdir = r_xdir;
    w_nydir = r_ydir;
    w_pt1   = 1'b0;
    w_pt2   = 1'b0;

    if (r_ydir == DIR_POS) begin
      w_ny = w_by + L_BS;
      if (w_ny >= L_YMAX) begin
        w_ny    = L_YMAX;
        w_nydir = DIR_NEG;
      end
    end else begin
      w_ny = w_by - L_BS;
      if (w_ny <= L_ZERO) begin
        w_ny    = L_ZERO;
        w_nydir = DIR_POS;
      end
    end

    if (r_xdir == DIR_NEG) begin
      if (w_bx - L_BS <= L_XL) begin
        if ((w_by + L_SZ > to_s(w_p1_y)) && (w_by < to_s(w_p1_y) + L_PH)) begin
          w_nx    = L_XL_HIT;
          w_nxdir = DIR_POS;
        end else begin
          w_pt2 = 1'b1;
        end
      end else begin
        w_nx = w_bx - L_BS;
      end
    end else begin
      if (w_bx + L_SZ + L_BS >= L_XR) begin
        if ((w_by + L_SZ > to_s(w_p2_y)) && (w_by < to_s(w_p2_y) + L_PH)) begin
          w_nx    = L_XR_HIT;
          w_nxdir = DIR_NEG;
        end else begin
          w_pt1 = 1'b1;
        end
      end else begin
        w_nx = w_bx + L_BS;
      end
    end
  end

  // Game FSM with ball, score, serve-timer and winner registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bx     <= L_BX_C;
      r_by     <= L_BY_C;
      r_xdir   <= DIR_POS;
      r_ydir   <= DIR_POS;
      r_cnt    <= '0;
      r_score1 <= '0;
      r_score2 <= '0;
      r_point1 <= 1'b0;
      r_point2 <= 1'b0;
      r_winner <= WIN_NONE;
    end else begin
      r_point1 <= 1'b0;
      r_point2 <= 1'b0;
      case (r_state)
        IDLE, GAMEOVER: begin
          if (bus.start) begin
            r_state  <= SERVE;
            r_bx     <= L_BX_C;
            r_by     <= L_BY_C;
            r_xdir   <= DIR_POS;
            r_ydir   <= DIR_POS;
            r_cnt    <= '0;
            r_score1 <= '0;
            r_score2 <= '0;
            r_winner <= WIN_NONE;
          end
        end
        SERVE: begin
          if (bus.tick) begin
            if (r_cnt == L_LAST) begin
              r_state <= PLAY;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        PLAY: begin
          if (bus.tick) begin
            // A point overrides any bounce: the ball re-centres regardless
            if (w_pt1 || w_pt2) begin
              r_bx   <= L_BX_C;
              r_by   <= L_BY_C;
              r_cnt  <= '0;
              r_xdir <= w_pt1 ? DIR_POS : DIR_NEG;
              if (w_pt1) begin
                r_point1 <= 1'b1;
                r_score1 <= w_s1_inc;
                if (w_s1_inc == L_WIN) begin
                  r_winner <= WIN_P1;
                  r_state  <= GAMEOVER;
                end else begin
                  r_state <= SERVE;
                end
              end else begin
                r_point2 <= 1'b1;
                r_score2 <= w_s2_inc;
                if (w_s2_inc == L_WIN) begin
                  r_winner <= WIN_P2;
                  r_state  <= GAMEOVER;
                end else begin
                  r_state <= SERVE;
                end
              end
            end else begin
              r_bx   <= w_nx[POS_W-1:0];
              r_by   <= w_ny[POS_W-1:0];
              r_xdir <= w_nxdir;
              r_ydir <= w_nydir;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.state_out = r_state;
  assign bus.p1_y      = w_p1_y;
  assign bus.p2_y      = w_p2_y;
  assign bus.ball_x    = r_bx;
  assign bus.ball_y    = r_by;
  assign bus.score1    = r_score1;
  assign bus.score2    = r_score2;
  assign bus.point1    = r_point1;
  assign bus.point2    = r_point2;
  assign bus.winner    = r_winner;

endmodule

// File: doc/pong_core.md
# pong_core

Parametrised Pong game engine: it tracks two paddles, one ball, and two scores, and advances the game once per frame tick. It replaces the fixed-size paddle/ball state machine. It sits between the debounced button inputs and the VGA renderer, which reads its registered positions. It adds configurable field geometry and speeds, saturating paddle motion, scoring, a timed serve, and a win condition.

## Interface
Parameters:
- FIELD_W, 640, field width in pixels; x grows rightward.
- FIELD_H, 480, field height in pixels; y grows downward, top = 0.
- PAD_H, 64, paddle height.
- PAD_X_L, 24, x of the left paddle's right (hitting) face.
- PAD_X_R, 616, x of the right paddle's left (hitting) face.
- BALL_SZ, 8, ball side length (square).
- PAD_SPEED, 4, paddle pixels per tick.
- BALL_SPEED, 2, ball pixels per tick on each axis.
- SERVE_TICKS, 60, ticks the ball is held at centre before each serve.
- WIN_SCORE, 7, score that ends the game.
- SCORE_W, 4, score counter width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- tick, in, 1, one-cycle frame strobe; all game motion happens only on tick cycles.
- start, in, 1, level; begins or restarts a game.
- p1_up / p1_dn / p2_up / p2_dn, in, 1 each, button levels.
- state_out, out, 3, current FSM state.
- p1_y / p2_y, out, 10 each, paddle top edges.
- ball_x / ball_y, out, 10 each, ball top-left corner.
- score1 / score2, out, SCORE_W each, player scores.
- point1 / point2, out, 1 each, one-cycle pulses when a point is scored.
- winner, out, 2, 00 = none, 01 = player 1, 10 = player 2.

## Operation
- States: IDLE, SERVE, PLAY, GAMEOVER.
- IDLE --start--> SERVE.
- SERVE --SERVE_TICKS ticks--> PLAY.
- PLAY --miss--> SERVE, or to GAMEOVER if that point makes a score reach WIN_SCORE.
- GAMEOVER --start--> SERVE.
- start is sampled on any cycle in IDLE or GAMEOVER. On entry to SERVE from either state: scores clear, winner = 00, serve direction = right/down.
- On entry to SERVE:
  - Ball is placed at ((FIELD_W-BALL_SZ)/2, (FIELD_H-BALL_SZ)/2).
  - Serve counter clears.
  - x direction points toward the player who conceded the last point.
  - y direction is kept.
- Paddles move on ticks in SERVE and PLAY only.
  - up → y -= PAD_SPEED, saturating at 0.
  - dn → y += PAD_SPEED, saturating at FIELD_H-PAD_H.
  - up and dn together → no move.
- Ball motion, each PLAY tick, with separate x and y direction bits:
  - Vertical: the next y is clamped to [0, FIELD_H-BALL_SZ]. Reaching a bound flips the y direction.
  - Moving left with ball_x - BALL_SPEED <= PAD_X_L: it is a hit if ball_y+BALL_SZ > p1_y and ball_y < p1_y+PAD_H. A hit sets x = PAD_X_L+1 and flips the x direction. A miss gives player 2 a point.
  - Moving right with ball_x + BALL_SZ + BALL_SPEED >= PAD_X_R: same test against p2_y. A hit sets x = PAD_X_R-BALL_SZ-1 and flips the x direction. A miss gives player 1 a point.
  - The hit test uses paddle positions registered before this tick, not this tick's update.
  - A miss with a simultaneous vertical bounce: the point takes priority; y is irrelevant because the ball re-centres.
- Scoring: on a point, the score increments, the matching point pulse asserts, and the FSM leaves PLAY. When the score reaches WIN_SCORE, winner is set and the FSM enters GAMEOVER. Scores never exceed WIN_SCORE.
- Arithmetic is done at 11 bits signed internally so subtractions cannot wrap. Outputs are 10-bit unsigned.

## Timing
- All outputs are registered. Updates on a tick cycle are visible the cycle after that tick.
- point1/point2 are high for exactly the one cycle after the scoring tick.
- The start → SERVE transition takes 1 cycle. tick is not required.
- Reset values:
  - state = IDLE.
  - paddles = (FIELD_H-PAD_H)/2.
  - ball at centre.
  - scores = 0, winner = 00, points = 0.
  - direction = right/down.
- Reset mid-game: same values are applied the next cycle, and any in-progress serve count is discarded.
- A tick in IDLE or GAMEOVER has no effect.

## Structure
- Shared package pong_pkg holds:
  - the state enum;
  - the direction typedef;
  - the position width constant (10);
  - the winner encodings.
- Sub-module pong_paddle: saturating up/down position register with parameters PAD_H, FIELD_H, PAD_SPEED, and an enable input. It is instantiated twice, enabled in SERVE and PLAY.

## Test plan
- Reset, then start and 60 ticks → state reaches PLAY. Ball at (316,236). Paddles at 208.
- Hold p1_up for 60 ticks from 208 → p1_y reaches 0 after 52 ticks and stays 0. p1_up with p1_dn → no change.
- Ball moving left with p1_y aligned → x direction flips at the left face, ball_x = 25, score unchanged.
- Ball moving left with p1_y = 0 and ball_y = 400 → point2 pulses one cycle, score2 = 1, state = SERVE, ball re-centred, serve direction left.
- Player 1 scores 7 points → winner = 01, state = GAMEOVER, ticks ignored. Then start → scores cleared, SERVE.
- Assert rst mid-PLAY → next cycle all outputs equal their reset values.
